// File: rtl/hmac_drbg_nonce_seq_pkg.sv
// hmac_drbg_pkg: shared state encoding and constants for the HMAC-DRBG nonce sequencer
package hmac_drbg_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_K1, S_V1, S_K2, S_V2, S_T, S_CHCK, S_K3, S_V3, S_DONE, S_ERR
  } state_t;
  localparam logic [7:0] K_INIT = 8'h00;
  localparam logic [7:0] V_INIT = 8'h01;
  localparam logic [7:0] SEP_00 = 8'h00;
  localparam logic [7:0] SEP_01 = 8'h01;
  localparam logic [383:0] GROUP_ORD_DEF =
    384'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFC7634D81F4372DDF581A0DB248B0A77AECEC196ACCC52973;
endpackage

// File: rtl/hmac_drbg_nonce_seq_range_chk.sv
// hmac_drbg_range_chk: registered 0 < cand < q acceptance flag
module hmac_drbg_range_chk #(
  parameter int DW = 384,
  parameter logic [DW-1:0] Q = '1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] cand,
  output logic          ok
);
  always_ff @(posedge clk)
    if (rst) ok <= 1'b0;
    else if (en) ok <= (|cand) && (cand < Q);
endmodule

// File: rtl/hmac_drbg_nonce_seq.sv
// hmac_drbg_nonce_seq: RFC 6979 style HMAC-DRBG sequencer driving an external HMAC core
module hmac_drbg_nonce_seq
  import hmac_drbg_pkg::*;
#(
  parameter int DW = 384,
  parameter int MAX_RETRY = 4,
  parameter logic [DW-1:0] GROUP_ORD = DW'(GROUP_ORD_DEF)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            zeroize,
  input  logic            init,
  input  logic            mode,
  input  logic [DW-1:0]   seed,
  input  logic [DW-1:0]   privkey,
  input  logic [DW-1:0]   hashed_msg,
  output logic            ready,
  output logic            valid,
  output logic            error,
  output logic [DW-1:0]   nonce,
  output logic            hmac_start,
  output logic [DW-1:0]   hmac_key,
  output logic [DW-1:0]   hmac_v,
  output logic            hmac_sep_en,
  output logic [7:0]      hmac_sep,
  output logic            hmac_data_en,
  output logic [2*DW-1:0] hmac_data,
  input  logic            hmac_ready,
  input  logic            hmac_tag_valid,
  input  logic [DW-1:0]   hmac_tag
);
  localparam int RW = $clog2(MAX_RETRY + 1);
  state_t state, state_n;
  logic [DW-1:0] k, v, cand;
  logic [2*DW-1:0] data;
  logic [RW-1:0] retry_cnt;
  logic mode_q, issued, ok, clr, hmac_st, tag_hit, k_st, fire;
  assign clr = reset | zeroize;
  assign hmac_st = state inside {S_K1, S_V1, S_K2, S_V2, S_T, S_K3, S_V3};
  assign k_st = state inside {S_K1, S_K2, S_K3};
  assign tag_hit = hmac_st & issued & hmac_tag_valid;
  assign fire = hmac_st & ~issued & hmac_ready;
  assign hmac_key = k;
  assign hmac_v = v;
  assign hmac_data = data;
  assign hmac_sep_en = k_st;
  assign hmac_sep = state == S_K2 ? SEP_01 : SEP_00;
  assign hmac_data_en = state inside {S_K1, S_K2};
  hmac_drbg_range_chk #(.DW(DW), .Q(GROUP_ORD)) u_chk (
    .clk(clk), .rst(clr), .en(state == S_T && tag_hit), .cand(hmac_tag), .ok(ok)
  );
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: state_n = init ? S_K1 : S_IDLE;
      S_K1:   state_n = tag_hit ? S_V1 : S_K1;
      S_V1:   state_n = tag_hit ? S_K2 : S_V1;
      S_K2:   state_n = tag_hit ? S_V2 : S_K2;
      S_V2:   state_n = tag_hit ? S_T : S_V2;
      S_T:    state_n = tag_hit ? S_CHCK : S_T;
      S_K3:   state_n = tag_hit ? S_V3 : S_K3;
      S_V3:   state_n = tag_hit ? S_T : S_V3;
      S_CHCK: state_n = (!mode_q || ok) ? S_DONE : (retry_cnt == RW'(MAX_RETRY - 1)) ? S_ERR : S_K3;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    state <= clr ? S_IDLE : state_n;
  always_ff @(posedge clk) begin
    if (clr) begin
      k <= '0;
      v <= '0;
      cand <= '0;
      data <= '0;
      nonce <= '0;
      retry_cnt <= '0;
      mode_q <= 1'b0;
      issued <= 1'b0;
      ready <= 1'b1;
      valid <= 1'b0;
      error <= 1'b0;
      hmac_start <= 1'b0;
    end else begin
      hmac_start <= fire;
      if (fire) issued <= 1'b1;
      if (tag_hit) begin
        issued <= 1'b0;
        if (k_st) k <= hmac_tag;
        else v <= hmac_tag;
        if (state == S_T) cand <= hmac_tag;
      end
      if (state == S_IDLE && init) begin
        k <= {DW/8{K_INIT}};
        v <= {DW/8{V_INIT}};
        mode_q <= mode;
        data <= mode ? {privkey, hashed_msg} : {seed, {DW{1'b0}}};
        retry_cnt <= '0;
        ready <= 1'b0;
        valid <= 1'b0;
        error <= 1'b0;
      end
      if (state == S_CHCK && mode_q && !ok) retry_cnt <= retry_cnt + RW'(1);
      if (state == S_DONE) begin
        nonce <= cand;
        valid <= 1'b1;
        ready <= 1'b1;
      end
      if (state == S_ERR) begin
        nonce <= '0;
        error <= 1'b1;
        ready <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_hmac_drbg_nonce_seq.sv
// tb_hmac_drbg_nonce_seq: table-driven bench with a behavioural HMAC responder
module tb_hmac_drbg_nonce_seq;
  localparam int DW = 384;
  typedef logic [2*DW-1:0] wide_t;
  localparam logic [DW-1:0] Q =
    384'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFC7634D81F4372DDF581A0DB248B0A77AECEC196ACCC52973;
  localparam logic [DW-1:0] VI = {48{8'h01}};
  logic clk = 1'b0, reset = 1'b1, zeroize = 1'b0, init = 1'b0, mode = 1'b0;
  logic [DW-1:0] seed = '0, privkey = '0, hashed_msg = '0;
  logic ready, valid, error, hmac_start, hmac_sep_en, hmac_data_en;
  logic [DW-1:0] nonce, hmac_key, hmac_v;
  logic [7:0] hmac_sep;
  logic [2*DW-1:0] hmac_data;
  logic hmac_ready = 1'b1, hmac_tag_valid = 1'b0;
  logic [DW-1:0] hmac_tag = '0;
  hmac_drbg_nonce_seq #(.DW(DW), .MAX_RETRY(4)) dut (
    .clk(clk), .reset(reset), .zeroize(zeroize), .init(init), .mode(mode),
    .seed(seed), .privkey(privkey), .hashed_msg(hashed_msg),
    .ready(ready), .valid(valid), .error(error), .nonce(nonce),
    .hmac_start(hmac_start), .hmac_key(hmac_key), .hmac_v(hmac_v),
    .hmac_sep_en(hmac_sep_en), .hmac_sep(hmac_sep), .hmac_data_en(hmac_data_en),
    .hmac_data(hmac_data), .hmac_ready(hmac_ready), .hmac_tag_valid(hmac_tag_valid),
    .hmac_tag(hmac_tag)
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  task automatic chk(input string name, input wide_t act, input wide_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask
  function automatic logic [DW-1:0] f(input logic [DW-1:0] key, input logic [DW-1:0] val,
                                      input logic se, input logic [7:0] s, input logic de,
                                      input logic [2*DW-1:0] d);
    logic [DW-1:0] r;
    r = key ^ {val[DW-2:0], val[DW-1]} ^ {48{se ? s + 8'h5A : 8'hA5}};
    if (de) r = r + d[2*DW-1:DW] + (d[DW-1:0] << 3);
    return r + {12{32'h9E3779B9}};
  endfunction
  logic ov_en = 1'b0, zero_all = 1'b0;
  logic [DW-1:0] ov_val = '0;
  int lat_fix = 0;
  function automatic logic [DW-1:0] ovr(input int n, input logic [DW-1:0] x);
    if (zero_all && n >= 5 && (n - 5) % 3 == 0) return '0;
    if (ov_en && n == 5) return ov_val;
    return x;
  endfunction
  int starts = 0;
  logic unstable = 1'b0;
  logic [DW-1:0] f_key, f_v;
  logic f_se, f_de;
  logic [7:0] f_sep;
  logic [2*DW-1:0] f_d;
  initial forever begin
    @(negedge clk);
    if (hmac_start) begin
      logic [DW-1:0] ck, cv, tag;
      logic cse, cde;
      logic [7:0] cs;
      logic [2*DW-1:0] cd;
      int lat;
      starts++;
      ck = hmac_key; cv = hmac_v; cse = hmac_sep_en; cs = hmac_sep; cde = hmac_data_en; cd = hmac_data;
      if (starts == 1) begin
        f_key = ck; f_v = cv; f_se = cse; f_sep = cs; f_de = cde; f_d = cd;
      end
      tag = ovr(starts, f(ck, cv, cse, cs, cde, cd));
      lat = lat_fix > 0 ? lat_fix : int'($urandom_range(1, 20));
      for (int i = 0; i < lat; i++) begin
        @(negedge clk);
        if (hmac_start || hmac_key !== ck || hmac_v !== cv || hmac_sep_en !== cse ||
            hmac_sep !== cs || hmac_data_en !== cde || hmac_data !== cd) unstable = 1'b1;
      end
      hmac_tag = tag;
      hmac_tag_valid = 1'b1;
      @(negedge clk);
      hmac_tag_valid = 1'b0;
    end
  end
  typedef struct {
    logic mode;
    logic [DW-1:0] seed, priv, hmsg;
    logic ov_en;
    logic [DW-1:0] ov_val;
    logic zero_all;
    int exp_starts;
    logic exp_err;
  } vec_t;
  vec_t vecs[8];
  function automatic logic [DW-1:0] model(input vec_t t);
    logic [DW-1:0] k, v;
    logic [2*DW-1:0] d;
    int n;
    d = t.mode ? {t.priv, t.hmsg} : {t.seed, {DW{1'b0}}};
    k = '0;
    v = VI;
    k = f(k, v, 1'b1, 8'h00, 1'b1, d);
    v = f(k, v, 1'b0, 8'h00, 1'b0, '0);
    k = f(k, v, 1'b1, 8'h01, 1'b1, d);
    v = f(k, v, 1'b0, 8'h00, 1'b0, '0);
    n = 4;
    for (int r = 0; r < 4; r++) begin
      n++;
      v = ovr(n, f(k, v, 1'b0, 8'h00, 1'b0, '0));
      if (!t.mode || (v != '0 && v < Q)) return v;
      k = f(k, v, 1'b1, 8'h00, 1'b0, '0);
      v = f(k, v, 1'b0, 8'h00, 1'b0, '0);
      n += 2;
    end
    return '0;
  endfunction
  task automatic wait_ready(output bit done);
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      done = ready;
    end
  endtask
  task automatic run_vec(input int idx);
    vec_t t;
    logic [DW-1:0] exp;
    bit done;
    t = vecs[idx];
    ov_en = t.ov_en; ov_val = t.ov_val; zero_all = t.zero_all; lat_fix = 0;
    exp = model(t);
    @(negedge clk);
    starts = 0; unstable = 1'b0;
    mode = t.mode; seed = t.seed; privkey = t.priv; hashed_msg = t.hmsg; init = 1'b1;
    @(negedge clk);
    init = 1'b0; mode = ~mode; seed = ~seed; privkey = ~privkey; hashed_msg = hashed_msg ^ 1;
    chk("busy_ready", wide_t'(ready), wide_t'(0));
    chk("init_clears_valid", wide_t'(valid), wide_t'(0));
    chk("init_clears_error", wide_t'(error), wide_t'(0));
    wait_ready(done);
    chk("done_timeout", wide_t'(done), wide_t'(1));
    chk("starts", wide_t'(starts), wide_t'(t.exp_starts));
    chk("valid", wide_t'(valid), wide_t'(!t.exp_err));
    chk("error", wide_t'(error), wide_t'(t.exp_err));
    chk("nonce", wide_t'(nonce), wide_t'(exp));
    chk("first_key", wide_t'(f_key), wide_t'(0));
    chk("first_v", wide_t'(f_v), wide_t'(VI));
    chk("first_sep", wide_t'({f_se, f_sep, f_de}), wide_t'({1'b1, 8'h00, 1'b1}));
    chk("first_data", f_d, t.mode ? {t.priv, t.hmsg} : {t.seed, {DW{1'b0}}});
    chk("stable_fields", wide_t'(unstable), wide_t'(0));
  endtask
  initial begin
    bit done;
    logic [DW-1:0] exp;
    vec_t kg;
    vecs[0] = '{1'b0, '0, '0, '0, 1'b0, '0, 1'b0, 5, 1'b0};
    vecs[1] = '{1'b1, '0, 384'd1, '0, 1'b1, '1, 1'b0, 8, 1'b0};
    vecs[2] = '{1'b1, '0, 384'd5, 384'd7, 1'b0, '0, 1'b1, 14, 1'b1};
    vecs[3] = '{1'b1, '0, 384'hABCD, 384'h1234, 1'b1, Q, 1'b0, 8, 1'b0};
    vecs[4] = '{1'b1, '0, 384'h77, 384'h99, 1'b1, Q - 384'd1, 1'b0, 5, 1'b0};
    vecs[5] = '{1'b0, 384'hABC, '0, '0, 1'b1, '0, 1'b0, 5, 1'b0};
    vecs[6] = '{1'b1, '0, 384'h3, 384'h4, 1'b1, 384'd1, 1'b0, 5, 1'b0};
    vecs[7] = '{1'b0, {12{32'hDEADBEEF}}, '0, '0, 1'b0, '0, 1'b0, 5, 1'b0};
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", wide_t'(ready), wide_t'(1));
    chk("rst_flags", wide_t'({valid, error, hmac_start}), wide_t'(0));
    chk("rst_nonce", wide_t'(nonce), wide_t'(0));
    chk("rst_kv", {hmac_key, hmac_v}, wide_t'(0));
    for (int i = 0; i < 8; i++) run_vec(i);
    kg = '{1'b0, 384'h5EED, '0, '0, 1'b0, '0, 1'b0, 5, 1'b0};
    ov_en = 1'b0; zero_all = 1'b0; lat_fix = 4;
    @(negedge clk);
    starts = 0;
    mode = 1'b0; seed = kg.seed; init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      done = starts == 4;
    end
    chk("zero_reach_v2", wide_t'(done), wide_t'(1));
    @(negedge clk);
    zeroize = 1'b1;
    @(negedge clk);
    zeroize = 1'b0;
    repeat (30) @(negedge clk);
    chk("zero_starts", wide_t'(starts), wide_t'(4));
    chk("zero_ready", wide_t'(ready), wide_t'(1));
    chk("zero_flags", wide_t'({valid, error}), wide_t'(0));
    chk("zero_kv", {hmac_key, hmac_v}, wide_t'(0));
    lat_fix = 0;
    exp = model(kg);
    starts = 0;
    mode = 1'b0; seed = kg.seed; init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    repeat (6) @(negedge clk);
    mode = 1'b1; privkey = 384'h1; init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    wait_ready(done);
    chk("busy_init_done", wide_t'(done), wide_t'(1));
    chk("busy_init_starts", wide_t'(starts), wide_t'(5));
    chk("busy_init_nonce", wide_t'(nonce), wide_t'(exp));
    chk("busy_init_valid", wide_t'(valid), wide_t'(1));
    repeat (30) @(negedge clk);
    starts = 0;
    init = 1'b1; zeroize = 1'b1;
    @(negedge clk);
    init = 1'b0; zeroize = 1'b0;
    chk("initzero_ready", wide_t'(ready), wide_t'(1));
    repeat (10) @(negedge clk);
    chk("initzero_starts", wide_t'(starts), wide_t'(0));
    chk("initzero_valid", wide_t'(valid), wide_t'(0));
    chk("initzero_nonce", wide_t'(nonce), wide_t'(0));
    chk("initzero_kv", {hmac_key, hmac_v}, wide_t'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
